regbank_sb: RTL
===============

Name: regbank_sb

Overview:
Parametrised successor to the 2-read/1-write register bank. Adds configurable depth, width and read-port count, registered (1-cycle) reads, and a per-register busy scoreboard for pipeline hazard tracking. Sits between the decode/issue stage (reads, reservations) and the writeback stage (writes). Register 0 is hardwired to zero and is never busy.

Parameters:
- NUM_REGS, 32, number of registers; power of 2, at least 4.
- DATA_W, 32, register width in bits.
- NUM_RD, 2, number of read ports, 1..4.
- ADDR_W, $clog2(NUM_REGS), address width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset (asserted when 0, sampled on rising clk).
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port p occupies bits [p*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  packed registered read data.
- rd_busy  out  NUM_RD  combinational busy flag of rd_addr[p] from the current scoreboard.
- wr_en  in  1  writeback write enable.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- rsv_en  in  1  reserve destination (marks busy).
- rsv_addr  in  ADDR_W  destination register to reserve.
- busy_cnt  out  ADDR_W+1  registered count of busy registers.
- any_busy  out  1  registered; 1 when busy_cnt != 0.

Behaviour:
- Reset (reset==0 at a clk edge):
  - all registers become 0; busy vector cleared.
  - rd_data = 0, busy_cnt = 0, any_busy = 0.
  - reset overrides wr_en and rsv_en in the same cycle.
  - reset mid-operation drops all reservations.
- Write: on a clk edge with wr_en=1 and wr_addr!=0, reg[wr_addr] <= wr_data and busy[wr_addr] <= 0. Writes to address 0 are ignored.
- Reserve: on a clk edge with rsv_en=1 and rsv_addr!=0, busy[rsv_addr] <= 1. Reserving address 0 is ignored.
- Reserve and write to the same nonzero address in the same cycle: busy ends at 1 (the newer reservation wins); the data is still written.
- Re-reserving an already busy register: stays busy; busy_cnt does not double-count.
- Writing a register that is not busy: data is written; busy stays 0 (a legal untracked write).
- Read:
  - rd_addr sampled at a clk edge; rd_data[p] presents the value one cycle later and holds until the next edge.
  - address 0 always returns 0.
  - without the optional feature, a same-edge write to the read address returns the OLD value.
- rd_busy[p]: combinational, equal to busy[rd_addr[p]] before the current edge's updates; always 0 for address 0.
- busy_cnt: equals the popcount of the busy vector after the edge. Maximum value is NUM_REGS-1.
- No back-pressure: every request is accepted every cycle.

Optional Feature:
- Macro REGBANK_BYPASS_EN.
- Defined:
  - a read sampled on the same edge as a write to the same nonzero address returns wr_data (write-first forwarding).
  - rd_busy[p] reads 0 when wr_en=1, wr_addr==rd_addr[p] and there is no same-cycle reservation of that address.
- Undefined: read-old-value behaviour and rd_busy exactly as in Behaviour.

Decomposition:
- Package regbank_pkg holds:
  - defaults for DATA_W and NUM_REGS.
  - the ZERO_REG constant (address 0).
  - a popcount function used for busy_cnt.
- One sub-module, regbank_scoreboard, owns the busy vector, rd_busy lookup, busy_cnt and any_busy. The top level owns the storage array and read registers.

Test Plan:
- Reset plus default fill: hold reset=0 for 2 cycles, then release. Write reg[k]=10*k for k=0..31. Read pairs (k, k+1) → rd_data shows 10*k one cycle after sampling; reg0 reads 0.
- Reg0 protection: wr_en with wr_addr=0, wr_data=20, then rsv_addr=0 → rd_data for addr 0 is 0; rd_busy=0; busy_cnt=0.
- Scoreboard lifecycle: reserve 5 then 9 → busy_cnt=2, rd_busy for addr 5 is 1. Write 5 ← 55 → busy_cnt=1; reading 5 returns 55 next cycle.
- Simultaneous reserve and write to 7 with data 77 → busy[7]=1, reg[7]=77, busy_cnt increments by 1.
- Same-edge read/write of reg 3 (old value 30, new value 99):
  - without REGBANK_BYPASS_EN → rd_data=30.
  - with it → 99.
  - the next read returns 99 in both builds.
- Mid-operation reset: reserve 4 registers and write reg 12=120, then assert reset for 1 cycle → busy_cnt=0, any_busy=0, reg 12 reads 0.

Source files
------------

// File: rtl/regbank_pkg.sv
// Shared constants and helpers for the regbank_sb register bank and its scoreboard.
package regbank_pkg;

  localparam int unsigned DATA_W_DEF   = 32;
  localparam int unsigned NUM_REGS_DEF = 32;
  localparam int unsigned NUM_RD_DEF   = 2;
  localparam int unsigned ZERO_REG     = 0;

  // popcount() takes a fixed-width vector; callers zero-extend, so NUM_REGS must not exceed POP_MAX.
  localparam int unsigned POP_MAX = 256;
  localparam int unsigned POP_W   = $clog2(POP_MAX) + 1;

  function automatic logic [POP_W-1:0] popcount(input logic [POP_MAX-1:0] v);
    logic [POP_W-1:0] cnt;
    cnt = '0;
    for (int unsigned i = 0; i < POP_MAX; i++) begin
      cnt = cnt + POP_W'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/regbank_sb_if.sv
// Issue/writeback bus of the register bank: reads, reservations, writes and scoreboard status.
interface regbank_sb_if
  import regbank_pkg::*;
#(
  parameter int unsigned NUM_REGS = NUM_REGS_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned NUM_RD   = NUM_RD_DEF
);
  localparam int unsigned ADDR_W = $clog2(NUM_REGS);

  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     rsv_en;
  logic [ADDR_W-1:0]        rsv_addr;
  logic [ADDR_W:0]          busy_cnt;
  logic                     any_busy;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    input  rd_data, rd_busy, busy_cnt, any_busy
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    output rd_data, rd_busy, busy_cnt, any_busy
  );

endinterface

// File: rtl/regbank_scoreboard.sv
// Per-register busy tracking for hazard detection; register 0 is never busy.
// REGBANK_BYPASS_EN: a same-cycle write (without a re-reservation) hides busy on the read port.
module regbank_scoreboard
  import regbank_pkg::*;
#(
  parameter int unsigned NUM_REGS = NUM_REGS_DEF,
  parameter int unsigned NUM_RD   = NUM_RD_DEF
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_RD*$clog2(NUM_REGS)-1:0] rd_addr_i,
  input  logic                              wr_en_i,
  input  logic [$clog2(NUM_REGS)-1:0]       wr_addr_i,
  input  logic                              rsv_en_i,
  input  logic [$clog2(NUM_REGS)-1:0]       rsv_addr_i,
  output logic [NUM_RD-1:0]                 rd_busy_o,
  output logic [$clog2(NUM_REGS):0]         busy_cnt_o,
  output logic                              any_busy_o
);
  localparam int unsigned ADDR_W = $clog2(NUM_REGS);
  localparam int unsigned CNT_W  = ADDR_W + 1;

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [CNT_W-1:0]    busy_cnt_q;
  logic                any_busy_q;

  // Clear on writeback first, then set on reservation so the newer reservation wins.
  always_comb begin
    busy_d = busy_q;
    if (wr_en_i && (wr_addr_i != ADDR_W'(ZERO_REG))) busy_d[wr_addr_i] = 1'b0;
    if (rsv_en_i && (rsv_addr_i != ADDR_W'(ZERO_REG))) busy_d[rsv_addr_i] = 1'b1;
  end

  always_comb begin
    rd_busy_o = '0;
    for (int unsigned p = 0; p < NUM_RD; p++) begin
`ifdef REGBANK_BYPASS_EN
      if (wr_en_i && (wr_addr_i == rd_addr_i[p*ADDR_W +: ADDR_W]) &&
          !(rsv_en_i && (rsv_addr_i == rd_addr_i[p*ADDR_W +: ADDR_W]))) begin
        rd_busy_o[p] = 1'b0;
      end else begin
        rd_busy_o[p] = busy_q[rd_addr_i[p*ADDR_W +: ADDR_W]];
      end
`else
      rd_busy_o[p] = busy_q[rd_addr_i[p*ADDR_W +: ADDR_W]];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      busy_q     <= '0;
      busy_cnt_q <= '0;
      any_busy_q <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      busy_cnt_q <= CNT_W'(popcount(POP_MAX'(busy_d)));
      any_busy_q <= |busy_d;
    end
  end

  assign busy_cnt_o = busy_cnt_q;
  assign any_busy_o = any_busy_q;

endmodule

// File: rtl/regbank_sb.sv
// Parametrised register bank with registered multi-port reads and a busy scoreboard.
// REGBANK_BYPASS_EN: a read sampled with a same-address write returns the new data.
module regbank_sb
  import regbank_pkg::*;
#(
  parameter int unsigned NUM_REGS = NUM_REGS_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned NUM_RD   = NUM_RD_DEF
) (
  input logic          clk,
  input logic          reset,
  regbank_sb_if.slave  bus
);
  localparam int unsigned ADDR_W = $clog2(NUM_REGS);

  logic [DATA_W-1:0]        regs_q [NUM_REGS];
  logic [NUM_RD*DATA_W-1:0] rd_data_q, rd_data_d;
  logic                     wr_hit_c;

  assign wr_hit_c = bus.wr_en && (bus.wr_addr != ADDR_W'(ZERO_REG));

  always_comb begin
    rd_data_d = '0;
    for (int unsigned p = 0; p < NUM_RD; p++) begin
      if (bus.rd_addr[p*ADDR_W +: ADDR_W] != ADDR_W'(ZERO_REG)) begin
`ifdef REGBANK_BYPASS_EN
        if (wr_hit_c && (bus.wr_addr == bus.rd_addr[p*ADDR_W +: ADDR_W])) begin
          rd_data_d[p*DATA_W +: DATA_W] = bus.wr_data;
        end else begin
          rd_data_d[p*DATA_W +: DATA_W] = regs_q[bus.rd_addr[p*ADDR_W +: ADDR_W]];
        end
`else
        rd_data_d[p*DATA_W +: DATA_W] = regs_q[bus.rd_addr[p*ADDR_W +: ADDR_W]];
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      rd_data_q <= '0;
    end else begin
      if (wr_hit_c) regs_q[bus.wr_addr] <= bus.wr_data;
      rd_data_q <= rd_data_d;
    end
  end

  assign bus.rd_data = rd_data_q;

  regbank_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_RD   (NUM_RD)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .rd_addr_i  (bus.rd_addr),
    .wr_en_i    (bus.wr_en),
    .wr_addr_i  (bus.wr_addr),
    .rsv_en_i   (bus.rsv_en),
    .rsv_addr_i (bus.rsv_addr),
    .rd_busy_o  (bus.rd_busy),
    .busy_cnt_o (bus.busy_cnt),
    .any_busy_o (bus.any_busy)
  );

endmodule
